fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side drain engine for the FIFO block. Drives the FIFO's pop and accepts its registered data_out,
//  which arrives one cycle after the pop. Presents the words as a valid/ready stream with packet framing (m_last).
//  Supports a flush that discards everything buffered and everything in the FIFO.
//  Sits between a FIFO instance and any downstream consumer that may apply backpressure.
// PARAMETERS
//  N_BITS     64  data word width; must equal the width of the attached FIFO
//  OUT_DEPTH  4   internal output buffer entries; power of 2, >=2; >=3 required for one word per cycle
//  PKT_LEN    8   beats per packet for m_last generation; >=1
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        reset, asynchronous, active-low
//  fifo_empty  in   1        FIFO empty flag
//  fifo_data   in   N_BITS   FIFO data_out; valid the cycle after fifo_pop
//  fifo_pop    out  1        pop request to the FIFO
//  m_valid     out  1        output word valid
//  m_ready     in   1        downstream accept
//  m_data      out  N_BITS   output word
//  m_last      out  1        final beat of a packet; qualified by m_valid
//  flush       in   1        single-cycle flush request
//  flush_done  out  1        one-cycle pulse when a flush completes
// BEHAVIOUR
//  - Reset: fifo_pop=0, m_valid=0, m_data=0, m_last=0, flush_done=0, buffer empty, inflight=0, beat_cnt=0, state=RUN.
//  - Reset mid-operation discards buffered words and any in-flight pop.
//  - inflight: 1-bit register = fifo_pop of the previous cycle.
//  - Pop timing: fifo_pop high in cycle k -> fifo_data sampled at the end of cycle k+1, only if inflight=1.
//    The sampled word is written to the buffer tail and m_valid can rise in cycle k+2 (latency 2).
//  - Pop rule in RUN, all terms registered (fifo_pop has no combinational path from m_ready):
//      fifo_pop = !fifo_empty && (count + inflight < OUT_DEPTH)
//  - Output: m_valid = (count != 0) in RUN; m_data = buffer head.
//    A transfer occurs when m_valid && m_ready; the head advances on each transfer.
//  - Hold: m_data and m_last stay stable while m_valid && !m_ready.
//  - Write and read of the buffer in the same cycle: count is unchanged and pointers wrap modulo OUT_DEPTH.
//  - No overflow by construction: count + inflight never exceeds OUT_DEPTH.
//  - fifo_data is ignored when inflight=0.
//  - Framing: beat_cnt counts transfers 0..PKT_LEN-1 and wraps to 0. m_last = m_valid && (beat_cnt == PKT_LEN-1).
//  - FSM:
//      RUN   --flush--> FLUSH
//      FLUSH: m_valid=0; buffer cleared on entry; fifo_pop = !fifo_empty every cycle; returned data discarded.
//             Exit to DONE when fifo_empty && !inflight.
//      DONE: flush_done=1 for one cycle; beat_cnt=0; then RUN.
//  - flush is ignored in FLUSH and DONE. flush in the same cycle as a transfer: that transfer completes, then FLUSH.
//  - Writer pushing during FLUSH: those words are also drained. Completion requires one cycle with fifo_empty=1 and inflight=0.
// CONFIGURATION
//  - Macro FIFO_RD_STATS_EN defined: adds outputs beat_count[31:0] (transfers) and stall_count[31:0]
//    (cycles with m_valid && !m_ready). Both saturate at all-ones and clear only on reset.
//  - Macro FIFO_RD_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package fifo_rd_pkg: enum rd_state_e {RUN, FLUSH, DONE}; localparam STAT_W=32.
//  - Sub-module rd_skid_buf: OUT_DEPTH x N_BITS circular buffer with head/tail/count, wr, rd and clr ports.
//  - Top level: FSM, pop/credit logic, beat counter, optional stats.
// TESTING
//  1. Reset with FIFO holding 3 words -> all outputs 0. After release, first fifo_pop in cycle 1 and m_valid in cycle 3.
//  2. 16 words A0..A15 with m_ready=1 throughout -> one transfer per cycle after 2-cycle fill; order preserved.
//     m_last on A7 and A15.
//  3. m_ready=0 for 10 cycles with 8 words queued -> count reaches 4 and fifo_pop stays 0.
//     m_data is held stable; after m_ready=1, words arrive in order with none lost or duplicated.
//  4. flush after 5 of 12 words transferred -> m_valid=0 and remaining 7 words popped and discarded.
//     flush_done pulses once; next packet's m_last comes after 8 new beats.
//  5. Alternating fifo_empty (single word trickle) with m_ready toggling -> no pop while empty.
//     No spurious m_valid; data matches scoreboard.
//  6. rst_n asserted with inflight=1 and count=2 -> outputs 0 immediately; post-reset stream starts cleanly.
//  7. With FIFO_RD_STATS_EN defined: 6 transfers and 4 stall cycles -> beat_count=6, stall_count=4.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side drain engine.
// Optional statistics counters are enabled with the FIFO_RD_STATS_EN macro.
package fifo_rd_pkg;

  // Drain engine operating states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } rd_state_e;

  // Width of the optional statistics counters.
  localparam int STAT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (&value) ? value : value + STAT_W'(1);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Small circular buffer holding words already popped from the FIFO.
// OUT_DEPTH must be a power of two so the pointers wrap naturally.
// Read data is forced to zero while the buffer is empty.
module rd_skid_buf #(
  parameter int N_BITS    = 64,
  parameter int OUT_DEPTH = 4,
  localparam int PTR_W    = $clog2(OUT_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [N_BITS-1:0] wr_data_i,
  input  logic              rd_i,
  output logic [N_BITS-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [N_BITS-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Next pointer/occupancy: clear wins, otherwise simultaneous write and read keep count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_i) tail_d = tail_q + PTR_W'(1);
      if (rd_i) head_d = head_q + PTR_W'(1);
      case ({wr_i, rd_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Word storage; a clear in the same cycle drops the incoming word.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
    if (wr_i && !clr_i) mem_q[tail_q] <= wr_data_i;
  end

  assign rd_data_o = (count_q != '0) ? mem_q[head_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops an attached FIFO (registered data_out, one
// cycle after pop), buffers the words and presents them as a valid/ready
// stream with m_last framing every PKT_LEN beats. A flush discards all
// buffered and in-FIFO words and ends with a one-cycle flush_done pulse.
// Define FIFO_RD_STATS_EN to add saturating beat_count/stall_count outputs.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int N_BITS    = 64,
  parameter int OUT_DEPTH = 4,
  parameter int PKT_LEN   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [N_BITS-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_BITS-1:0] m_data,
  output logic              m_last,
  input  logic              flush,
  output logic              flush_done
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0] beat_count,
  output logic [STAT_W-1:0] stall_count
`endif
);

  localparam int CNT_W  = $clog2(OUT_DEPTH) + 1;
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(OUT_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  rd_state_e         state_q, state_d;
  logic              started_q;
  logic              inflight_q;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              buf_wr;
  logic              buf_clr;
  logic              xfer;

  // Buffered words plus the one possibly still in flight from the FIFO.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign xfer      = m_valid && m_ready;

  rd_skid_buf #(
    .N_BITS    (N_BITS),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (buf_clr),
    .wr_i      (buf_wr),
    .wr_data_i (fifo_data),
    .rd_i      (xfer),
    .rd_data_o (m_data),
    .count_o   (count)
  );

  // State, next-state and pop/valid decode; pop depends only on registers and fifo_empty.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    fifo_pop   = 1'b0;
    m_valid    = 1'b0;
    flush_done = 1'b0;
    buf_wr     = 1'b0;
    buf_clr    = 1'b0;
    case (state_q)
      RUN: begin
        // started_q keeps the pop low in the first cycle after reset release.
        fifo_pop = started_q && !fifo_empty && (occupancy < DEPTH_C);
        m_valid  = (count != '0);
        buf_wr   = inflight_q;
        if (flush) begin
          // This cycle's transfer still completes; the clear drops the rest.
          state_d = FLUSH;
          buf_clr = 1'b1;
        end
      end
      FLUSH: begin
        // Keep popping; returned words are never written to the buffer.
        fifo_pop = !fifo_empty;
        if (fifo_empty && !inflight_q) state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Packet beat counter: advance per transfer, wrap at PKT_LEN, restart after a flush.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == DONE) begin
      beat_cnt_d = '0;
    end else if (xfer) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_W'(1);
    end
  end

  assign m_last = m_valid && (beat_cnt_q == LAST_BEAT);

  // Control registers: state, startup gate, in-flight pop tracker, beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      started_q  <= 1'b0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      started_q  <= 1'b1;
      inflight_q <= fifo_pop;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [STAT_W-1:0] beat_count_q;
  logic [STAT_W-1:0] stall_count_q;

  // Saturating transfer and stall counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      if (xfer)                beat_count_q  <= sat_inc(beat_count_q);
      if (m_valid && !m_ready) stall_count_q <= sat_inc(stall_count_q);
    end
  end

  assign beat_count  = beat_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a queue-based FIFO model feeds
// the DUT, and a scoreboard of popped words (cleared on flush) predicts the
// output stream and its m_last framing. Also covers FIFO_RD_STATS_EN builds.
module tb_fifo_stream_reader;

  localparam int N_BITS    = 64;
  localparam int OUT_DEPTH = 4;
  localparam int PKT_LEN   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [N_BITS-1:0] fifo_data = '0;
  logic              fifo_pop;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [N_BITS-1:0] m_data;
  logic              m_last;
  logic              flush = 1'b0;
  logic              flush_done;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]       beat_count;
  logic [31:0]       stall_count;
`endif

  fifo_stream_reader #(
    .N_BITS    (N_BITS),
    .OUT_DEPTH (OUT_DEPTH),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .flush      (flush),
    .flush_done (flush_done)
`ifdef FIFO_RD_STATS_EN
    ,
    .beat_count (beat_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and reference model state.
  logic [N_BITS-1:0] fq[$];
  logic [N_BITS-1:0] exp_q[$];
  bit   force_empty = 1'b0;
  bit   fl_mode = 1'b0;
  bit   hold_prev = 1'b0;
  logic [N_BITS-1:0] prev_data;
  logic prev_last;
  int   beats = 0;
  int   rx = 0;
  int   discarded = 0;
  int   done_pulses = 0;
  int   first_last = -1;

  // Values sampled in the most recent cycle.
  logic s_pop, s_valid, s_last, s_done;
  logic [N_BITS-1:0] s_data;

  typedef struct {
    logic              ready;
    logic              exp_pop;
    logic              exp_valid;
    logic              exp_last;
    logic [N_BITS-1:0] exp_data;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs are already set at the falling edge.
  task automatic cycle();
    logic [N_BITS-1:0] w;
    bit xfer;
    bit flush_acc;
    fifo_empty = force_empty || (fq.size() == 0);
    #1;
    s_pop   = fifo_pop;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_done  = flush_done;
    check("pop_while_empty", s_pop & fifo_empty, 0);
    check("occupancy_bound", exp_q.size() <= OUT_DEPTH, 1);
    if (fl_mode) check("valid_during_flush", s_valid, 0);
    if (hold_prev) begin
      check("hold_valid", s_valid, 1);
      check("hold_data", s_data, prev_data);
      check("hold_last", s_last, prev_last);
    end
    xfer = s_valid && m_ready;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", s_valid, 0);
      end else begin
        w = exp_q.pop_front();
        check("stream_data", s_data, w);
        check("stream_last", s_last, (beats == PKT_LEN - 1));
        beats = (beats + 1) % PKT_LEN;
        rx++;
        if (s_last && first_last < 0) first_last = rx;
      end
    end
    flush_acc = flush && !fl_mode;
    if (s_done) begin
      check("done_without_flush", fl_mode, 1);
      fl_mode = 1'b0;
      beats = 0;
      done_pulses++;
    end
    if (flush_acc) begin
      discarded += exp_q.size();
      exp_q.delete();
      fl_mode = 1'b1;
    end
    hold_prev = s_valid && !m_ready && !flush_acc;
    prev_data = s_data;
    prev_last = s_last;
    @(posedge clk);
    #1;
    if (s_pop && !fifo_empty) begin
      w = fq.pop_front();
      fifo_data = w;
      if (fl_mode) discarded++;
      else exp_q.push_back(w);
    end else begin
      fifo_data = {$urandom, $urandom};
    end
    @(negedge clk);
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    flush = 1'b0;
    force_empty = 1'b0;
    fifo_empty = (fq.size() == 0);
    exp_q.delete();
    fl_mode = 1'b0;
    hold_prev = 1'b0;
    beats = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    force_empty = 1'b0;
    flush = 1'b0;
    m_ready = 1'b1;
    while ((fq.size() != 0 || exp_q.size() != 0 || fl_mode) && n < budget) begin
      cycle();
      n++;
    end
    check(name, n < budget, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop"},   fifo_pop, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_data"},  m_data, 0);
    check({tag, "_last"},  m_last, 0);
    check({tag, "_done"},  flush_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, disc0, dp0, n, pushed;

    @(negedge clk);

    // Reset with three words waiting, then startup latency.
    for (int i = 0; i < 3; i++) fq.push_back(64'h1111_0000_0000_0000 + 64'(i));
    start_reset();
    #1;
    check_reset_outputs("t1_reset");
    release_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c == 0) check("t1_pop_c0", s_pop, 0);
      if (c == 1) check("t1_pop_c1", s_pop, 1);
      if (c == 2) check("t1_valid_c2", s_valid, 0);
      if (c == 3) begin
        check("t1_valid_c3", s_valid, 1);
        check("t1_data_c3", s_data, 64'h1111_0000_0000_0000);
      end
    end
    drain("t1_drain", 50);

    // Sixteen words at full rate, checked cycle by cycle from a table.
    for (int c = 0; c < 20; c++) begin
      vecs[c].ready     = 1'b1;
      vecs[c].exp_pop   = (c >= 1 && c <= 16);
      vecs[c].exp_valid = (c >= 3 && c <= 18);
      vecs[c].exp_last  = (c >= 3 && c <= 18) && (((c - 3) % PKT_LEN) == PKT_LEN - 1);
      vecs[c].exp_data  = 64'hA0A0_0000_0000_0000 + 64'(c - 3);
    end
    for (int i = 0; i < 16; i++) fq.push_back(64'hA0A0_0000_0000_0000 + 64'(i));
    start_reset();
    release_reset();
    for (int c = 0; c < 20; c++) begin
      m_ready = vecs[c].ready;
      cycle();
      check($sformatf("t2_pop_c%0d", c), s_pop, vecs[c].exp_pop);
      check($sformatf("t2_valid_c%0d", c), s_valid, vecs[c].exp_valid);
      check($sformatf("t2_last_c%0d", c), s_last, vecs[c].exp_last);
      if (vecs[c].exp_valid) check($sformatf("t2_data_c%0d", c), s_data, vecs[c].exp_data);
    end
    drain("t2_drain", 50);

    // Backpressure: eight words queued, consumer stalled for ten cycles.
    for (int i = 0; i < 8; i++) fq.push_back(64'hC0C0_0000_0000_0000 + 64'(i));
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 4) check("t3_no_pop_when_full", s_pop, 0);
    end
    check("t3_buffered", exp_q.size(), OUT_DEPTH);
    check("t3_fifo_left", fq.size(), 4);
    rx0 = rx;
    drain("t3_drain", 60);
    check("t3_rx", rx - rx0, 8);

    // Flush after five of twelve words.
    for (int i = 0; i < 12; i++) fq.push_back(64'hD0D0_0000_0000_0000 + 64'(i));
    rx0 = rx;
    disc0 = discarded;
    dp0 = done_pulses;
    m_ready = 1'b1;
    n = 0;
    while (rx - rx0 < 5 && n < 50) begin
      cycle();
      n++;
    end
    check("t4_five_timeout", n < 50, 1);
    m_ready = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    n = 0;
    while (done_pulses == dp0 && n < 50) begin
      cycle();
      n++;
    end
    check("t4_done_timeout", n < 50, 1);
    repeat (3) cycle();
    check("t4_done_pulses", done_pulses - dp0, 1);
    check("t4_rx", rx - rx0, 5);
    check("t4_discarded", discarded - disc0, 7);
    check("t4_fifo_drained", fq.size(), 0);
    for (int i = 0; i < 10; i++) fq.push_back(64'hE0E0_0000_0000_0000 + 64'(i));
    rx0 = rx;
    first_last = -1;
    drain("t4_drain", 60);
    check("t4_rx_after", rx - rx0, 10);
    check("t4_last_after_8", first_last - rx0, PKT_LEN);

    // Single-word trickle with toggling ready.
    for (int i = 0; i < 10; i++) fq.push_back(64'hF0F0_0000_0000_0000 + 64'(i));
    rx0 = rx;
    for (int i = 0; i < 60; i++) begin
      force_empty = (i % 2 == 0);
      m_ready = 1'($urandom % 2);
      cycle();
    end
    drain("t5_drain", 60);
    check("t5_rx", rx - rx0, 10);

    // Reset while two words are buffered and one is in flight.
    for (int i = 0; i < 6; i++) fq.push_back(64'h6060_0000_0000_0000 + 64'(i));
    start_reset();
    release_reset();
    m_ready = 1'b0;
    repeat (4) cycle();
    #1;
    check("t6_valid_before", m_valid, 1);
    check("t6_popped_before", exp_q.size(), 3);
    start_reset();
    #1;
    check_reset_outputs("t6_reset");
    release_reset();
    rx0 = rx;
    drain("t6_drain", 60);
    check("t6_rx", rx - rx0, 3);

    // Randomized traffic with writer activity, stalls and flushes.
    rx0 = rx;
    disc0 = discarded;
    pushed = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 3 == 0 && fq.size() < 24) begin
        fq.push_back({$urandom, $urandom});
        pushed++;
      end
      force_empty = ($urandom % 4 == 0);
      m_ready = ($urandom % 4 != 0);
      flush = ($urandom % 64 == 0);
      cycle();
    end
    drain("rand_drain", 400);
    check("rand_conservation", (rx - rx0) + (discarded - disc0), pushed);

`ifdef FIFO_RD_STATS_EN
    // Six transfers and four stall cycles.
    for (int i = 0; i < 6; i++) fq.push_back(64'h7070_0000_0000_0000 + 64'(i));
    start_reset();
    release_reset();
    m_ready = 1'b0;
    repeat (7) cycle();
    drain("t7_drain", 60);
    #1;
    check("t7_beat_count", beat_count, 6);
    check("t7_stall_count", stall_count, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
